// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and
// the counter-width helper.
package serial_sub_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Counter width is clog2(WIDTH), but never narrower than one bit.
    function automatic int calc_cw(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - z, bo = borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ z;
    assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction sequencer: one fs_cell is stepped LSB first over
// WIDTH cycles with a registered borrow chain, then the result is published.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = calc_cw(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_next;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             cell_d, cell_bo;

    fs_cell u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .z  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        // Shift-in form that also works when WIDTH is 1.
        sh_next            = sh_q >> 1;
        sh_next[WIDTH-1]   = cell_d;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = sh_next;
                brw_d = cell_bo;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = sh_next;
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == SHIFT) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 instance for the main plan,
// WIDTH=1 instance for the single-bit corner.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       start1;
    logic [0:0] a1, b1;
    logic       bin1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation. Cycle k is the interval after edge E(k-1), so the
    // done pulse belongs to cycle 9. With inject set, start is re-pulsed with
    // different operands in cycles 3 and 8; the run must ignore them.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic binv, input logic [7:0] exp_d, input logic exp_bo,
                          input logic [7:0] prev_d, input logic prev_bo, input bit inject);
        start = 1'b1; a = av; b = bv; bin = binv;
        tick();
        start = 1'b0; a = 8'hA5; b = 8'h5A; bin = ~binv;
        for (int k = 1; k <= 9; k++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " done"}, {31'd0, done}, {31'd0, (k == 9)});
            if (k < 9) begin
                chk({tag, " diff hold"}, {24'd0, diff}, {24'd0, prev_d});
                chk({tag, " bout hold"}, {31'd0, bout}, {31'd0, prev_bo});
            end else begin
                chk({tag, " diff"}, {24'd0, diff}, {24'd0, exp_d});
                chk({tag, " bout"}, {31'd0, bout}, {31'd0, exp_bo});
            end
            if (inject && (k == 3 || k == 8)) begin
                start = 1'b1; a = 8'h00; b = 8'hFF; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " idle done"}, {31'd0, done}, 32'd0);
        chk({tag, " idle diff"}, {24'd0, diff}, {24'd0, exp_d});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        tick(); tick();
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst diff", {24'd0, diff}, 32'd0);
        chk("rst bout", {31'd0, bout}, 32'd0);
        chk("rst busy1", {31'd0, busy1}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("5A-3C",       8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("3C-5A",       8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 8'h1E, 1'b0, 1'b0);
        run_op("00-00-1",     8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hE2, 1'b1, 1'b0);
        run_op("FF-FF-1",     8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("10-01 retry", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 8'hFF, 1'b1, 1'b1);

        // Reset lands on shift edge E4; the partial result must vanish.
        start = 1'b1; a = 8'h77; b = 8'h11; bin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("midrst busy before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst diff", {24'd0, diff}, 32'd0);
        chk("midrst bout", {31'd0, bout}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("midrst no done", {31'd0, done}, 32'd0);
            tick();
        end

        run_op("05-03",       8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);

        // WIDTH=1: done in cycle 2 after the accepting edge.
        start1 = 1'b1; a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0;
        tick();
        start1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
        chk("w1 c1 busy", {31'd0, busy1}, 32'd1);
        chk("w1 c1 done", {31'd0, done1}, 32'd0);
        tick();
        chk("w1 c2 done", {31'd0, done1}, 32'd1);
        chk("w1 diff",    {31'd0, diff1}, 32'd1);
        chk("w1 bout",    {31'd0, bout1}, 32'd1);
        tick();
        chk("w1 c3 busy", {31'd0, busy1}, 32'd0);
        chk("w1 c3 done", {31'd0, done1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction sequencer: one shared 1-bit full-subtractor cell computes A - B - Bin over WIDTH clock cycles, LSB first.
- Controller latches operands on a start handshake, steps the cell once per cycle with a registered borrow chain, then publishes a WIDTH-bit difference and a borrow-out.
- Sits between a requester (e.g. ALU sequencer) and the subtractor cell; trades area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on clk rising edge.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  result register (A - B - Bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff A < B + Bin (unsigned).

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; busy=0, done=0, diff=0, bout=0; all internal operand, count and borrow registers = 0. Reset wins over every other event, including mid-SHIFT; the partial result is discarded and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 -> load a_r=a, b_r=b, brw=bin, cnt=0, sh=0; go to SHIFT.
  - start=0 -> stay.
- SHIFT, at each edge:
  - Cell inputs are a_r[0], b_r[0], brw.
  - sh <= {cell_diff, sh[WIDTH-1:1]}; brw <= cell_borrow.
  - a_r and b_r shift right by 1; cnt <= cnt+1.
  - When cnt==WIDTH-1 at that edge: load diff <= {cell_diff, sh[WIDTH-1:1]} and bout <= cell_borrow, then go to DONE.
- Shifts therefore occur at edges E1..E_WIDTH.
- DONE: done=1 for exactly one cycle, between edges E_WIDTH and E_WIDTH+1; next state IDLE.
- Latency: start accepted at E0; done visible after E_WIDTH; the earliest next accept is E_WIDTH+2.
- start while busy (SHIFT or DONE) is ignored: not queued, no effect on operands or result.
- diff/bout hold the previous result throughout SHIFT. They change only on the DONE-entry edge or on reset.
- a, b, bin may change freely after the accepting edge.
- Cell function:
  - cell_diff = x^y^z.
  - cell_borrow = (~x&y) | (~(x^y)&z).
- cnt width CW = max(1, clog2(WIDTH)). For WIDTH=1, SHIFT lasts one edge (cnt==0 terminates).
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is reported only via bout.

Decomposition:
- Package serial_sub_pkg:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Encoding 2'd3 is illegal and recovers to IDLE on the next edge.
  - Function computing CW from WIDTH.
- Sub-module fs_cell: the purely combinational 1-bit full-subtractor (x, y, z -> d, bo), instantiated once.
- FSM, counter, shift registers and result registers stay in serial_sub_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulsed -> done exactly 9 cycles after the accepting edge; diff=0x1E, bout=0; busy high for 9 cycles.
- a=0x3C, b=0x5A, bin=0 -> diff=0xE2, bout=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- Start operation (a=0x10, b=0x01); re-pulse start with a=0x00, b=0xFF during cycles 3 and 8 -> result 0x0F, bout=0; exactly one done pulse; diff keeps the prior value until the DONE-entry edge.
- rst_n low for one edge at shift cycle 4 -> busy=0, done never pulses, diff=0, bout=0. A new start (0x05-0x03) then yields diff=0x02, bout=0.
- WIDTH=1 build: a=0, b=1, bin=0 -> diff=1, bout=1, done 2 cycles after the accepting edge.
